// File: rtl/alu_issue_if.sv
// alu_issue_if: handshake, instruction, forwarding and ALU-side bundle for alu_issue.
// master = upstream/downstream environment, slave = the issue register.
`default_nettype none

interface alu_issue_if;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] instr;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic        fwd_ex_we;
    logic        fwd_ex_pend;
    logic [4:0]  fwd_ex_reg;
    logic [31:0] fwd_ex_data;
    logic        fwd_mem_we;
    logic [4:0]  fwd_mem_reg;
    logic [31:0] fwd_mem_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] alu_in1;
    logic [31:0] alu_in2;
    logic [3:0]  alu_func;
    logic [4:0]  dest_reg;
    logic        dest_we;
    logic        illegal;

    modport master (
        output flush, in_valid, instr, rs_data, rt_data,
               fwd_ex_we, fwd_ex_pend, fwd_ex_reg, fwd_ex_data,
               fwd_mem_we, fwd_mem_reg, fwd_mem_data, out_ready,
        input  in_ready, out_valid, alu_in1, alu_in2, alu_func,
               dest_reg, dest_we, illegal
    );

    modport slave (
        input  flush, in_valid, instr, rs_data, rt_data,
               fwd_ex_we, fwd_ex_pend, fwd_ex_reg, fwd_ex_data,
               fwd_mem_we, fwd_mem_reg, fwd_mem_data, out_ready,
        output in_ready, out_valid, alu_in1, alu_in2, alu_func,
               dest_reg, dest_we, illegal
    );
endinterface

`default_nettype wire

// File: rtl/alu_issue.sv
//==============================================================================
// alu_issue : MIPS decode + operand forwarding + valid/ready issue register
//             feeding the ALU. Macro ALU_ISSUE_FWD_EN enables EX/MEM
//             forwarding and the load-use interlock.
// Revision  : 1.0
//==============================================================================
`default_nettype none

module alu_issue #(
    parameter logic [3:0] RESET_FUNC = 4'b0100
) (
    input  wire logic   clk,
    input  wire logic   rst_n,
    alu_issue_if.slave  bus
);

    localparam logic [3:0] c_ALU_AND  = 4'b0000;
    localparam logic [3:0] c_ALU_OR   = 4'b0001;
    localparam logic [3:0] c_ALU_XOR  = 4'b0010;
    localparam logic [3:0] c_ALU_ADD  = 4'b0100;
    localparam logic [3:0] c_ALU_SUB  = 4'b1100;
    localparam logic [3:0] c_ALU_SLT  = 4'b1101;
    localparam logic [3:0] c_ALU_SLTU = 4'b0110;

    localparam logic [5:0] c_OP_RTYPE = 6'h00;
    localparam logic [5:0] c_OP_LUI   = 6'h0F;

    typedef enum logic [0:0] {
        S_EMPTY = 1'b0,
        S_FULL  = 1'b1
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;

    logic [31:0] r_alu_in1;
    logic [31:0] r_alu_in2;
    logic [3:0]  r_alu_func;
    logic [4:0]  r_dest_reg;
    logic        r_dest_we;
    logic        r_illegal;

    logic [5:0]  w_op;
    logic [5:0]  w_fn;
    logic [4:0]  w_rs_idx;
    logic [4:0]  w_rt_idx;
    logic [31:0] w_sext;
    logic [31:0] w_zext;
    logic [31:0] w_rs_val;
    logic [31:0] w_rt_val;
    logic        w_use_rs;
    logic        w_use_rt;
    logic        w_interlock;
    logic        w_in_ready;
    logic        w_accept;

    logic [31:0] w_in1;
    logic [31:0] w_in2;
    logic [3:0]  w_func;
    logic [4:0]  w_dest;
    logic        w_we;
    logic        w_ill;

    assign w_op     = bus.instr[31:26];
    assign w_fn     = bus.instr[5:0];
    assign w_rs_idx = bus.instr[25:21];
    assign w_rt_idx = bus.instr[20:16];
    assign w_sext   = {{16{bus.instr[15]}}, bus.instr[15:0]};
    assign w_zext   = {16'h0000, bus.instr[15:0]};
    assign w_use_rs = (w_op != c_OP_LUI);
    assign w_use_rt = (w_op == c_OP_RTYPE);

`ifdef ALU_ISSUE_FWD_EN
    logic w_rs_ex_hit;
    logic w_rt_ex_hit;
    logic w_rs_mem_hit;
    logic w_rt_mem_hit;

    // Register 0 never matches: it reads as zero and cannot stall.
    assign w_rs_ex_hit  = bus.fwd_ex_we  && (bus.fwd_ex_reg  == w_rs_idx) && (w_rs_idx != 5'd0);
    assign w_rt_ex_hit  = bus.fwd_ex_we  && (bus.fwd_ex_reg  == w_rt_idx) && (w_rt_idx != 5'd0);
    assign w_rs_mem_hit = bus.fwd_mem_we && (bus.fwd_mem_reg == w_rs_idx) && (w_rs_idx != 5'd0);
    assign w_rt_mem_hit = bus.fwd_mem_we && (bus.fwd_mem_reg == w_rt_idx) && (w_rt_idx != 5'd0);

    always_comb begin
        w_rs_val = bus.rs_data;
        if (w_rs_idx == 5'd0)  w_rs_val = 32'h0;
        else if (w_rs_ex_hit)  w_rs_val = bus.fwd_ex_data;
        else if (w_rs_mem_hit) w_rs_val = bus.fwd_mem_data;
    end

    always_comb begin
        w_rt_val = bus.rt_data;
        if (w_rt_idx == 5'd0)  w_rt_val = 32'h0;
        else if (w_rt_ex_hit)  w_rt_val = bus.fwd_ex_data;
        else if (w_rt_mem_hit) w_rt_val = bus.fwd_mem_data;
    end

    assign w_interlock = bus.fwd_ex_pend &&
                         ((w_use_rs && w_rs_ex_hit) || (w_use_rt && w_rt_ex_hit));
`else
    logic w_fwd_unused;

    assign w_fwd_unused = ^{bus.fwd_ex_we, bus.fwd_ex_pend, bus.fwd_ex_reg, bus.fwd_ex_data,
                            bus.fwd_mem_we, bus.fwd_mem_reg, bus.fwd_mem_data,
                            w_use_rs, w_use_rt};
    assign w_rs_val    = (w_rs_idx == 5'd0) ? 32'h0 : bus.rs_data;
    assign w_rt_val    = (w_rt_idx == 5'd0) ? 32'h0 : bus.rt_data;
    assign w_interlock = 1'b0;
`endif

    assign w_in_ready = !bus.flush && !w_interlock && ((r_state == S_EMPTY) || bus.out_ready);
    assign w_accept   = bus.in_valid && w_in_ready;

    always_comb begin
        w_func = RESET_FUNC;
        w_in1  = 32'h0;
        w_in2  = 32'h0;
        w_dest = 5'd0;
        w_we   = 1'b0;
        w_ill  = 1'b0;
        case (w_op)
            c_OP_RTYPE: begin
                w_in1  = w_rs_val;
                w_in2  = w_rt_val;
                w_dest = bus.instr[15:11];
                w_we   = 1'b1;
                case (w_fn)
                    6'h20, 6'h21: w_func = c_ALU_ADD;
                    6'h22, 6'h23: w_func = c_ALU_SUB;
                    6'h24:        w_func = c_ALU_AND;
                    6'h25:        w_func = c_ALU_OR;
                    6'h26:        w_func = c_ALU_XOR;
                    6'h2A:        w_func = c_ALU_SLT;
                    6'h2B:        w_func = c_ALU_SLTU;
                    default: begin
                        w_in1  = 32'h0;
                        w_in2  = 32'h0;
                        w_dest = 5'd0;
                        w_we   = 1'b0;
                        w_ill  = 1'b1;
                    end
                endcase
            end
            6'h08, 6'h09, 6'h0A, 6'h0B, 6'h23: begin
                w_in1  = w_rs_val;
                w_in2  = w_sext;
                w_dest = w_rt_idx;
                w_we   = 1'b1;
                w_func = (w_op == 6'h0A) ? c_ALU_SLT :
                         (w_op == 6'h0B) ? c_ALU_SLTU : c_ALU_ADD;
            end
            6'h0C, 6'h0D, 6'h0E: begin
                w_in1  = w_rs_val;
                w_in2  = w_zext;
                w_dest = w_rt_idx;
                w_we   = 1'b1;
                w_func = (w_op == 6'h0C) ? c_ALU_AND :
                         (w_op == 6'h0D) ? c_ALU_OR : c_ALU_XOR;
            end
            c_OP_LUI: begin
                w_in2  = {bus.instr[15:0], 16'h0000};
                w_dest = w_rt_idx;
                w_we   = 1'b1;
                w_func = c_ALU_OR;
            end
            6'h2B: begin
                w_in1  = w_rs_val;
                w_in2  = w_sext;
                w_func = c_ALU_ADD;
            end
            default: w_ill = 1'b1;
        endcase
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_EMPTY: if (w_accept) w_state_nxt = S_FULL;
            S_FULL: begin
                if (bus.flush)                        w_state_nxt = S_EMPTY;
                else if (bus.out_ready && !w_accept)  w_state_nxt = S_EMPTY;
            end
            default: w_state_nxt = S_EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_EMPTY;
        else        r_state <= w_state_nxt;
    end

    // Flush keeps the operand fields for visibility but kills the writeback.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_alu_in1  <= 32'h0;
            r_alu_in2  <= 32'h0;
            r_alu_func <= RESET_FUNC;
            r_dest_reg <= 5'd0;
            r_dest_we  <= 1'b0;
            r_illegal  <= 1'b0;
        end else if (w_accept) begin
            r_alu_in1  <= w_in1;
            r_alu_in2  <= w_in2;
            r_alu_func <= w_func;
            r_dest_reg <= w_dest;
            r_dest_we  <= w_we;
            r_illegal  <= w_ill;
        end else if (bus.flush) begin
            r_dest_we  <= 1'b0;
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = (r_state == S_FULL);
    assign bus.alu_in1   = r_alu_in1;
    assign bus.alu_in2   = r_alu_in2;
    assign bus.alu_func  = r_alu_func;
    assign bus.dest_reg  = r_dest_reg;
    assign bus.dest_we   = r_dest_we;
    assign bus.illegal   = r_illegal;

endmodule

`default_nettype wire

// File: tb/tb_alu_issue.sv
// tb_alu_issue: randomized + directed scoreboard bench for alu_issue.
`default_nettype none

module tb_alu_issue;

    typedef struct packed {
        logic [31:0] in1;
        logic [31:0] in2;
        logic [3:0]  func;
        logic [4:0]  dest;
        logic        we;
        logic        ill;
    } exp_t;

    logic clk;
    logic rst_n;
    int   n_cmp = 0;
    int   n_err = 0;
    logic exp_full = 1'b0;
    exp_t q[$];

    alu_issue_if bus();

    alu_issue #(.RESET_FUNC(4'b0100)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic check_rec(input string tag, input exp_t e);
        check({tag, "_in1"},  bus.alu_in1,  e.in1);
        check({tag, "_in2"},  bus.alu_in2,  e.in2);
        check({tag, "_func"}, {28'h0, bus.alu_func}, {28'h0, e.func});
        check({tag, "_dest"}, {27'h0, bus.dest_reg}, {27'h0, e.dest});
        check({tag, "_we"},   {31'h0, bus.dest_we},  {31'h0, e.we});
        check({tag, "_ill"},  {31'h0, bus.illegal},  {31'h0, e.ill});
    endtask

    // Architectural operand value as the ALU should see it.
    function automatic logic [31:0] opv(input logic [4:0] r, input logic [31:0] rf);
        if (r == 0) return 32'h0;
`ifdef ALU_ISSUE_FWD_EN
        if (bus.fwd_ex_we && bus.fwd_ex_reg == r)   return bus.fwd_ex_data;
        if (bus.fwd_mem_we && bus.fwd_mem_reg == r) return bus.fwd_mem_data;
`endif
        return rf;
    endfunction

    function automatic logic stalled();
        logic [5:0] op;
        logic       hit_rs;
        logic       hit_rt;
        op = bus.instr[31:26];
        hit_rs = bus.instr[25:21] != 0 && bus.fwd_ex_reg == bus.instr[25:21];
        hit_rt = bus.instr[20:16] != 0 && bus.fwd_ex_reg == bus.instr[20:16];
`ifdef ALU_ISSUE_FWD_EN
        return bus.fwd_ex_we && bus.fwd_ex_pend &&
               ((op != 6'h0F && hit_rs) || (op == 6'h00 && hit_rt));
`else
        return 1'b0 & hit_rs & hit_rt & (op == 0);
`endif
    endfunction

    function automatic exp_t model(input logic [31:0] ins);
        exp_t        e;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] sx;
        logic [31:0] zx;
        a  = opv(ins[25:21], bus.rs_data);
        b  = opv(ins[20:16], bus.rt_data);
        sx = $signed(ins[15:0]);
        zx = ins[15:0];
        e  = '{in1: 32'h0, in2: 32'h0, func: 4'b0100, dest: 5'd0, we: 1'b0, ill: 1'b1};
        case (ins[31:26])
            6'h00: begin
                e = '{in1: a, in2: b, func: 4'b0100, dest: ins[15:11], we: 1'b1, ill: 1'b0};
                case (ins[5:0])
                    6'h20, 6'h21: e.func = 4'b0100;
                    6'h22, 6'h23: e.func = 4'b1100;
                    6'h24: e.func = 4'b0000;
                    6'h25: e.func = 4'b0001;
                    6'h26: e.func = 4'b0010;
                    6'h2A: e.func = 4'b1101;
                    6'h2B: e.func = 4'b0110;
                    default: e = '{in1: 32'h0, in2: 32'h0, func: 4'b0100, dest: 5'd0, we: 1'b0, ill: 1'b1};
                endcase
            end
            6'h08, 6'h09, 6'h23: e = '{in1: a, in2: sx, func: 4'b0100, dest: ins[20:16], we: 1'b1, ill: 1'b0};
            6'h0A: e = '{in1: a, in2: sx, func: 4'b1101, dest: ins[20:16], we: 1'b1, ill: 1'b0};
            6'h0B: e = '{in1: a, in2: sx, func: 4'b0110, dest: ins[20:16], we: 1'b1, ill: 1'b0};
            6'h0C: e = '{in1: a, in2: zx, func: 4'b0000, dest: ins[20:16], we: 1'b1, ill: 1'b0};
            6'h0D: e = '{in1: a, in2: zx, func: 4'b0001, dest: ins[20:16], we: 1'b1, ill: 1'b0};
            6'h0E: e = '{in1: a, in2: zx, func: 4'b0010, dest: ins[20:16], we: 1'b1, ill: 1'b0};
            6'h0F: e = '{in1: 32'h0, in2: {ins[15:0], 16'h0}, func: 4'b0001, dest: ins[20:16], we: 1'b1, ill: 1'b0};
            6'h2B: e = '{in1: a, in2: sx, func: 4'b0100, dest: 5'd0, we: 1'b0, ill: 1'b0};
            default: ;
        endcase
        return e;
    endfunction

    function automatic logic [31:0] rtype(input logic [4:0] rs, rt, rd, input logic [5:0] fn);
        return {6'h00, rs, rt, rd, 5'd0, fn};
    endfunction

    function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs, rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    task automatic idle();
        bus.flush = 0; bus.in_valid = 0; bus.instr = 0; bus.rs_data = 0; bus.rt_data = 0;
        bus.fwd_ex_we = 0; bus.fwd_ex_pend = 0; bus.fwd_ex_reg = 0; bus.fwd_ex_data = 0;
        bus.fwd_mem_we = 0; bus.fwd_mem_reg = 0; bus.fwd_mem_data = 0; bus.out_ready = 1;
    endtask

    task automatic issue(input logic [31:0] ins, input logic [31:0] rsd, rtd);
        bus.in_valid = 1; bus.instr = ins; bus.rs_data = rsd; bus.rt_data = rtd;
    endtask

    // One clock: check handshake, then track acceptance into the scoreboard.
    task automatic step();
        logic exp_rdy;
        logic acc;
        exp_t rec;
        @(negedge clk);
        exp_rdy = !bus.flush && !stalled() && (!exp_full || bus.out_ready);
        check("in_ready",  {31'h0, bus.in_ready},  {31'h0, exp_rdy});
        check("out_valid", {31'h0, bus.out_valid}, {31'h0, exp_full});
        acc = bus.in_valid && exp_rdy;
        rec = model(bus.instr);
        @(posedge clk);
        if (bus.flush && exp_full && q.size() > 0) void'(q.pop_front());
        if (acc) q.push_back(rec);
        if (acc)                 exp_full = 1'b1;
        else if (bus.flush)      exp_full = 1'b0;
        else if (bus.out_ready)  exp_full = 1'b0;
        #1;
    endtask

    // Monitor: every completed downstream transfer is checked against the queue head.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && bus.out_valid && bus.out_ready && !bus.flush) begin
                if (q.size() == 0) begin
                    check("sb_underflow", 32'h1, 32'h0);
                end else begin
                    e = q.pop_front();
                    check_rec("xfer", e);
                end
            end
        end
    end

    initial begin
        exp_t e;
        idle();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_rec("reset", '{in1: 32'h0, in2: 32'h0, func: 4'b0100, dest: 5'd0, we: 1'b0, ill: 1'b0});
        check("reset_valid", {31'h0, bus.out_valid}, 32'h0);
        rst_n = 1'b1;

        // Directed decode cases
        issue(rtype(5'd1, 5'd2, 5'd3, 6'h21), 32'd78375, 32'd42596); step();
        issue(itype(6'h0A, 5'd4, 5'd6, 16'h000F), 32'hFFFF_FFFF, 32'h0); step();
        issue(itype(6'h0B, 5'd4, 5'd6, 16'hFFFF), 32'h1234_5678, 32'h0); step();
        issue(itype(6'h0C, 5'd4, 5'd6, 16'hFF00), 32'hFFFF_FFFF, 32'h0); step();
        issue(itype(6'h0F, 5'd4, 5'd6, 16'hFFFF), 32'hDEAD_BEEF, 32'h0); step();
        bus.fwd_ex_we = 1; bus.fwd_ex_reg = 5; bus.fwd_ex_data = 32'hFF00_FF00;
        bus.fwd_mem_we = 1; bus.fwd_mem_reg = 5; bus.fwd_mem_data = 32'h1;
        issue(itype(6'h08, 5'd5, 5'd7, 16'h0001), 32'h5555_5555, 32'h0); step();
        bus.fwd_ex_reg = 0; bus.fwd_mem_reg = 0;
        issue(itype(6'h08, 5'd0, 5'd7, 16'h0002), 32'h7777_7777, 32'h0); step();
        issue(itype(6'h3F, 5'd1, 5'd2, 16'h1234), 32'h1, 32'h2); step();
        issue(itype(6'h2B, 5'd1, 5'd2, 16'h8000), 32'h100, 32'h2); step();
        idle(); step();

`ifdef ALU_ISSUE_FWD_EN
        bus.fwd_ex_we = 1; bus.fwd_ex_pend = 1; bus.fwd_ex_reg = 5; bus.fwd_ex_data = 32'hABCD_0000;
        issue(rtype(5'd5, 5'd6, 5'd7, 6'h24), 32'h0, 32'hFFFF_FFFF);
        repeat (2) step();
        bus.fwd_ex_pend = 0; step();
        idle(); step();
`endif

        // Stall for three cycles, then back-to-back transfer
        issue(rtype(5'd8, 5'd9, 5'd10, 6'h22), 32'd100, 32'd30); step();
        bus.out_ready = 0;
        issue(rtype(5'd8, 5'd9, 5'd11, 6'h2A), 32'd1, 32'd2);
        for (int i = 0; i < 3; i++) begin
            step();
            if (q.size() > 0) check_rec("hold", q[0]);
        end
        bus.out_ready = 1; step();
        issue(itype(6'h0E, 5'd12, 5'd13, 16'h00FF), 32'h0F0F_0F0F, 32'h0); step();
        idle(); step(); step();

        // Flush while full
        issue(itype(6'h0D, 5'd3, 5'd4, 16'h1111), 32'h2222_0000, 32'h0); step();
        idle(); bus.out_ready = 0;
        e = (q.size() > 0) ? q[0] : '0;
        bus.flush = 1; step();
        bus.flush = 0;
        check("flush_valid", {31'h0, bus.out_valid}, 32'h0);
        check("flush_we",    {31'h0, bus.dest_we},   32'h0);
        check("flush_in2",   bus.alu_in2, e.in2);
        bus.out_ready = 1; step();

        // Asynchronous reset mid-stream
        issue(rtype(5'd1, 5'd2, 5'd3, 6'h25), 32'h1, 32'h2); step();
        bus.out_ready = 0; idle(); bus.out_ready = 0;
        #2 rst_n = 1'b0;
        #1;
        check_rec("midreset", '{in1: 32'h0, in2: 32'h0, func: 4'b0100, dest: 5'd0, we: 1'b0, ill: 1'b0});
        check("midreset_valid", {31'h0, bus.out_valid}, 32'h0);
        q.delete();
        exp_full = 1'b0;
        @(posedge clk); #1 rst_n = 1'b1;
        bus.out_ready = 1; step();

        // Randomized traffic
        for (int n = 0; n < 800; n++) begin
            logic [5:0] ops[13] = '{6'h00, 6'h00, 6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C,
                                    6'h0D, 6'h0E, 6'h0F, 6'h23, 6'h2B, 6'h3F};
            logic [5:0] fns[10] = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25,
                                    6'h26, 6'h2A, 6'h2B, 6'h27};
            logic [31:0] ins;
            ins = {ops[$urandom_range(0, 12)], 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                   16'($urandom)};
            if (ins[31:26] == 6'h00) ins = rtype(ins[25:21], ins[20:16], 5'($urandom_range(0, 31)),
                                                 fns[$urandom_range(0, 9)]);
            bus.instr        = ins;
            bus.in_valid     = ($urandom % 4) != 0;
            bus.out_ready    = ($urandom % 3) != 0;
            bus.flush        = ($urandom % 25) == 0;
            bus.rs_data      = $urandom;
            bus.rt_data      = $urandom;
            bus.fwd_ex_we    = $urandom % 2;
            bus.fwd_ex_pend  = ($urandom % 5) == 0;
            bus.fwd_ex_reg   = 5'($urandom_range(0, 7));
            bus.fwd_ex_data  = $urandom;
            bus.fwd_mem_we   = $urandom % 2;
            bus.fwd_mem_reg  = 5'($urandom_range(0, 7));
            bus.fwd_mem_data = $urandom;
            step();
        end

        idle();
        repeat (3) step();
        check("drain", q.size(), 32'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
